arm_fetch: RTL



---
 rtl/arm_fetch.sv | 137 +++++++++++++
 1 files changed

// File: rtl/arm_fetch.sv
// rtl/arm_fetch.sv - instruction fetch unit: fetch PC, imem req/ack, prefetch queue, redirect
module arm_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        pc_we,
    input  logic [31:0] pc_in
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

    localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
    localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [2:0]  count_q, count_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    // Storage is sized for the largest legal DEPTH so 2-bit pointers always index in range.
    logic [31:0] q_pc_q   [4];
    logic [31:0] q_pc_d   [4];
    logic [31:0] q_inst_q [4];
    logic [31:0] q_inst_d [4];

    logic fire, push, pop, space;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imem_addr_d = imem_addr_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        q_pc_d      = q_pc_q;
        q_inst_d    = q_inst_q;

        fire = imem_req_q && imem_ack;
        push = fire && (state_q == S_WAIT) && !pc_we;
        pop  = (count_q != 3'd0) && inst_ready && !pc_we;

        // A redirect flushes everything and voids any same-edge push or pop.
        if (pc_we) begin
            count_d  = 3'd0;
            rd_ptr_d = 2'd0;
            wr_ptr_d = 2'd0;
            pc_d     = {pc_in[31:2], 2'b00};
        end else begin
            if (push) begin
                q_pc_d[wr_ptr_q]   = pc_q;
                q_inst_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d           = next_ptr(wr_ptr_q);
                pc_d               = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + {2'b00, push} - {2'b00, pop};
        end

        space = (count_d < DEPTH_C);

        case (state_q)
            S_IDLE: begin
                if (space) begin
                    state_d     = S_WAIT;
                    imem_addr_d = pc_d;
                end
            end
            S_WAIT, S_DROP: begin
                if (fire) begin
                    if (space) begin
                        state_d     = S_WAIT;
                        imem_addr_d = pc_d;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (pc_we) begin
                    // Request already on the bus must complete; its data is thrown away.
                    state_d = S_DROP;
                end
            end
            default: state_d = S_IDLE;
        endcase

        imem_req_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= {RESET_PC[31:2], 2'b00};
            imem_req_q  <= 1'b0;
            imem_addr_q <= 32'd0;
            count_q     <= 3'd0;
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                q_pc_q[i]   <= 32'd0;
                q_inst_q[i] <= 32'd0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            q_pc_q      <= q_pc_d;
            q_inst_q    <= q_inst_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign inst       = q_inst_q[rd_ptr_q];
    assign inst_pc    = q_pc_q[rd_ptr_q];
    assign inst_valid = (count_q != 3'd0);

endmodule
